// File: rtl/muldiv_unit_if.sv
// Issue/writeback bundle between the execute stage
// and the iterative RV32M multiply/divide unit.
interface muldiv_unit_if #(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5
);
  logic                  start;
  logic [2:0]            op;
  logic [DATA_W-1:0]     rs1_rdata;
  logic [DATA_W-1:0]     rs2_rdata;
  logic [REG_ADDR_W-1:0] rd_addr;
  logic                  flush;
  logic                  busy;
  logic                  done;
  logic                  rd_we;
  logic [REG_ADDR_W-1:0] waddr;
  logic [DATA_W-1:0]     wdata;

  modport master (
    output start, op, rs1_rdata, rs2_rdata,
    output rd_addr, flush,
    input  busy, done, rd_we, waddr, wdata
  );

  modport slave (
    input  start, op, rs1_rdata, rs2_rdata,
    input  rd_addr, flush,
    output busy, done, rd_we, waddr, wdata
  );
endinterface

// File: rtl/muldiv_unit.sv
// Radix-2 iterative RV32M multiply/divide unit.
// One product/quotient bit per cycle, regfile writeback on completion.
module muldiv_unit #(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5
) (
  input logic          clk,
  input logic          rst_n,
  muldiv_unit_if.slave bus
);
  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  localparam int XW = 2 * DATA_W;
  localparam logic [DATA_W-1:0] MIN_S =
    {1'b1, {(DATA_W-1){1'b0}}};

  state_t                state;
  logic [2:0]            op_q;
  logic [REG_ADDR_W-1:0] rd_q;
  logic [DATA_W-1:0]     opnd;
  logic [XW-1:0]         acc;
  logic [DATA_W:0]       rem;
  logic                  neg_q;
  logic                  rneg_q;
  logic [5:0]            cnt;
  logic                  done_q;
  logic                  we_q;
  logic [REG_ADDR_W-1:0] waddr_q;
  logic [DATA_W-1:0]     wdata_q;

  logic              is_div;
  logic              a_sgn;
  logic              b_sgn;
  logic              a_neg;
  logic              b_neg;
  logic [DATA_W-1:0] a_abs;
  logic [DATA_W-1:0] b_abs;
  logic              div0;
  logic              ovf;
  logic [DATA_W-1:0] fast_res;

  always_comb begin
    is_div = bus.op[2];
    a_sgn  = is_div ? ~bus.op[0]
                    : (bus.op[1] ^ bus.op[0]);
    b_sgn  = is_div ? ~bus.op[0]
                    : (bus.op[1:0] == 2'b01);
    a_neg  = a_sgn & bus.rs1_rdata[DATA_W-1];
    b_neg  = b_sgn & bus.rs2_rdata[DATA_W-1];
    a_abs  = a_neg ? -bus.rs1_rdata : bus.rs1_rdata;
    b_abs  = b_neg ? -bus.rs2_rdata : bus.rs2_rdata;
    div0   = is_div && (bus.rs2_rdata == '0);
    ovf    = is_div && !bus.op[0]
          && (bus.rs1_rdata == MIN_S)
          && (bus.rs2_rdata == '1);
    fast_res = '0;
    unique case (1'b1)
      div0: fast_res = bus.op[1] ? bus.rs1_rdata : '1;
      ovf:  fast_res = bus.op[1] ? '0 : MIN_S;
      default: fast_res = '0;
    endcase
  end

  logic [DATA_W:0]   mul_sum;
  logic [XW-1:0]     mul_nx;
  logic [DATA_W+1:0] div_sh;
  logic [DATA_W+1:0] div_df;
  logic              div_ok;
  logic [DATA_W:0]   rem_nx;
  logic [DATA_W-1:0] quo_nx;
  logic [XW-1:0]     prod_s;
  logic [DATA_W-1:0] quo_s;
  logic [DATA_W-1:0] rem_s;
  logic [DATA_W-1:0] calc_res;

  // Multiplier bits shift out of acc[0] while the
  // running sum shifts in from the top.
  always_comb begin
    mul_sum = {1'b0, acc[XW-1:DATA_W]}
            + (acc[0] ? {1'b0, opnd} : '0);
    mul_nx  = {mul_sum, acc[DATA_W-1:1]};
    div_sh  = {rem, acc[DATA_W-1]};
    div_df  = div_sh - {2'b00, opnd};
    div_ok  = ~div_df[DATA_W+1];
    rem_nx  = div_ok ? div_df[DATA_W:0]
                     : div_sh[DATA_W:0];
    quo_nx  = {acc[DATA_W-2:0], div_ok};
    prod_s  = neg_q ? -mul_nx : mul_nx;
    quo_s   = neg_q ? -quo_nx : quo_nx;
    rem_s   = rneg_q ? -rem_nx[DATA_W-1:0]
                     : rem_nx[DATA_W-1:0];
    if (op_q[2])
      calc_res = op_q[1] ? rem_s : quo_s;
    else if (op_q[1:0] == 2'b00)
      calc_res = prod_s[DATA_W-1:0];
    else
      calc_res = prod_s[XW-1:DATA_W];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      op_q    <= '0;
      rd_q    <= '0;
      opnd    <= '0;
      acc     <= '0;
      rem     <= '0;
      neg_q   <= 1'b0;
      rneg_q  <= 1'b0;
      cnt     <= '0;
      done_q  <= 1'b0;
      we_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          done_q <= 1'b0;
          we_q   <= 1'b0;
          if (bus.start && !bus.flush) begin
            op_q   <= bus.op;
            rd_q   <= bus.rd_addr;
            neg_q  <= a_neg ^ b_neg;
            rneg_q <= a_neg;
            opnd   <= is_div ? b_abs : a_abs;
            acc    <= {{DATA_W{1'b0}},
                       is_div ? a_abs : b_abs};
            rem    <= '0;
            cnt    <= '0;
            if (div0 || ovf) begin
              state   <= DONE;
              wdata_q <= fast_res;
              waddr_q <= bus.rd_addr;
              done_q  <= 1'b1;
              we_q    <= (bus.rd_addr != '0);
            end else begin
              state <= CALC;
            end
          end
        end
        CALC: begin
          if (bus.flush) begin
            state <= IDLE;
          end else begin
            if (op_q[2]) begin
              acc[DATA_W-1:0] <= quo_nx;
              rem <= rem_nx;
            end else begin
              acc <= mul_nx;
            end
            cnt <= cnt + 6'd1;
            if (cnt == 6'd31) begin
              state   <= DONE;
              wdata_q <= calc_res;
              waddr_q <= rd_q;
              done_q  <= 1'b1;
              we_q    <= (rd_q != '0);
            end
          end
        end
        DONE: begin
          state  <= IDLE;
          done_q <= 1'b0;
          we_q   <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // A flush in the completion cycle must kill the write.
  assign bus.busy  = (state != IDLE);
  assign bus.done  = done_q & ~bus.flush;
  assign bus.rd_we = we_q & ~bus.flush;
  assign bus.waddr = waddr_q;
  assign bus.wdata = wdata_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// Directed + random scoreboard bench for
// the iterative multiply/divide unit.
module tb_muldiv_unit;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  muldiv_unit_if #(.DATA_W(32), .REG_ADDR_W(5)) bus ();

  muldiv_unit #(.DATA_W(32), .REG_ADDR_W(5)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [31:0] data;
    logic [4:0]  rd;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int total = 0;
  int bad = 0;
  int done_cnt = 0;
  int we_cnt = 0;

  always @(negedge clk) begin
    if (bus.done) done_cnt++;
    if (bus.rd_we) we_cnt++;
  end

  task automatic chk(string tag, logic [31:0] obs,
                     logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model(
    logic [2:0] op, logic [31:0] a, logic [31:0] b);
    logic [63:0] p;
    logic signed [63:0] sa, sb, ub;
    logic ov;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    ub = {32'h0, b};
    ov = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (op)
      3'd0: begin p = sa * sb; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin
        p = {32'h0, a} * {32'h0, b};
        return p[63:32];
      end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (ov) return 32'h8000_0000;
        return $signed(a) / $signed(b);
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (ov) return 32'h0;
        return $signed(a) % $signed(b);
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int lat_of(
    logic [2:0] op, logic [31:0] a, logic [31:0] b);
    if (op[2] && b == 0) return 0;
    if (op[2] && !op[0] && a == 32'h8000_0000
        && b == 32'hFFFF_FFFF) return 0;
    return 32;
  endfunction

  task automatic issue(logic [2:0] op, logic [31:0] a,
                       logic [31:0] b, logic [4:0] rd,
                       logic [31:0] expd, int lat,
                       bit push);
    exp_t e;
    @(negedge clk);
    bus.start = 1'b1;
    bus.op = op;
    bus.rs1_rdata = a;
    bus.rs2_rdata = b;
    bus.rd_addr = rd;
    if (push) begin
      e.data = expd;
      e.rd = rd;
      e.lat = lat;
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
    bus.start = 1'b0;
  endtask

  task automatic finish_op(string tag);
    exp_t e;
    int k;
    k = 0;
    chk({tag, "_busy"}, {31'b0, bus.busy}, 32'd1);
    while (!bus.done && k < 40) begin
      @(posedge clk);
      #1;
      k++;
    end
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'd0, 32'd1);
      return;
    end
    e = sb.pop_front();
    chk({tag, "_done"}, {31'b0, bus.done}, 32'd1);
    chk({tag, "_lat"}, k, e.lat);
    chk({tag, "_we"}, {31'b0, bus.rd_we},
        {31'b0, (e.rd != 0)});
    chk({tag, "_waddr"}, {27'b0, bus.waddr},
        {27'b0, e.rd});
    chk({tag, "_wdata"}, bus.wdata, e.data);
    @(posedge clk);
    #1;
    chk({tag, "_idle"}, {31'b0, bus.busy}, 32'd0);
    chk({tag, "_pulse"}, {31'b0, bus.done}, 32'd0);
  endtask

  initial begin
    int dc;
    int wc;
    logic [2:0] rop;
    logic [31:0] ra;
    logic [31:0] rb;

    bus.start = 1'b0;
    bus.op = 3'd0;
    bus.rs1_rdata = '0;
    bus.rs2_rdata = '0;
    bus.rd_addr = '0;
    bus.flush = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", {31'b0, bus.busy}, 32'd0);
    chk("rst_done", {31'b0, bus.done}, 32'd0);
    chk("rst_we", {31'b0, bus.rd_we}, 32'd0);
    chk("rst_waddr", {27'b0, bus.waddr}, 32'd0);
    chk("rst_wdata", bus.wdata, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    issue(3'd0, 32'd7, 32'hFFFF_FFFD, 5'd5,
          32'hFFFF_FFEB, 32, 1);
    finish_op("mul");
    issue(3'd3, '1, '1, 5'd1, 32'hFFFF_FFFE, 32, 1);
    finish_op("mulhu");
    issue(3'd1, '1, '1, 5'd2, 32'h0, 32, 1);
    finish_op("mulh");
    issue(3'd2, '1, '1, 5'd3, 32'hFFFF_FFFF, 32, 1);
    finish_op("mulhsu");
    issue(3'd4, 32'hFFFF_FFF9, 32'd2, 5'd4,
          32'hFFFF_FFFD, 32, 1);
    finish_op("div");
    issue(3'd6, 32'hFFFF_FFF9, 32'd2, 5'd6,
          32'hFFFF_FFFF, 32, 1);
    finish_op("rem");
    issue(3'd5, 32'd100, 32'd7, 5'd7, 32'd14, 32, 1);
    finish_op("divu");
    issue(3'd7, 32'd100, 32'd7, 5'd8, 32'd2, 32, 1);
    finish_op("remu");
    issue(3'd5, 32'd5, 32'd0, 5'd9, '1, 0, 1);
    finish_op("divu0");
    issue(3'd7, 32'd5, 32'd0, 5'd10, 32'd5, 0, 1);
    finish_op("remu0");
    issue(3'd4, 32'h8000_0000, '1, 5'd11,
          32'h8000_0000, 0, 1);
    finish_op("div_ovf");
    issue(3'd6, 32'h8000_0000, '1, 5'd12, 32'd0, 0, 1);
    finish_op("rem_ovf");
    issue(3'd0, 32'd3, 32'd4, 5'd0, 32'd12, 32, 1);
    finish_op("mul_x0");

    for (int i = 0; i < 6; i++) begin
      rop = 3'($urandom_range(0, 7));
      ra = $urandom;
      rb = (i == 2) ? 32'd0 : $urandom;
      if (i == 4) rb = 32'($urandom_range(1, 9));
      issue(rop, ra, rb, 5'(i + 20), model(rop, ra, rb),
            lat_of(rop, ra, rb), 1);
      finish_op("rand");
    end

    dc = done_cnt;
    wc = we_cnt;
    issue(3'd0, 32'd9, 32'd9, 5'd13, 32'd0, 32, 0);
    repeat (10) @(posedge clk);
    @(negedge clk);
    bus.flush = 1'b1;
    #1;
    chk("fl_done", {31'b0, bus.done}, 32'd0);
    chk("fl_we", {31'b0, bus.rd_we}, 32'd0);
    @(posedge clk);
    #1;
    bus.flush = 1'b0;
    chk("fl_busy", {31'b0, bus.busy}, 32'd0);
    repeat (40) @(posedge clk);
    chk("fl_dcnt", done_cnt - dc, 32'd0);
    chk("fl_wcnt", we_cnt - wc, 32'd0);
    issue(3'd0, 32'd9, 32'd9, 5'd13, 32'd81, 32, 1);
    finish_op("fl_next");

    dc = done_cnt;
    wc = we_cnt;
    issue(3'd5, 32'd1000, 32'd3, 5'd14, 32'd0, 32, 0);
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mr_busy", {31'b0, bus.busy}, 32'd0);
    chk("mr_we", {31'b0, bus.rd_we}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(posedge clk);
    chk("mr_dcnt", done_cnt - dc, 32'd0);
    chk("mr_wcnt", we_cnt - wc, 32'd0);
    issue(3'd5, 32'd1000, 32'd3, 5'd14, 32'd333, 32, 1);
    finish_op("mr_next");

    dc = done_cnt;
    issue(3'd3, 32'h0001_0000, 32'h0003_0000, 5'd15,
          32'd3, 26, 1);
    repeat (5) @(posedge clk);
    @(negedge clk);
    bus.start = 1'b1;
    bus.op = 3'd5;
    bus.rs1_rdata = 32'd5;
    bus.rs2_rdata = 32'd0;
    bus.rd_addr = 5'd16;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    finish_op("ign");
    repeat (40) @(posedge clk);
    chk("ign_dcnt", done_cnt - dc, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
